rotate_seq: RTL and testbench

ROTATE_SEQ -- requirements
Module: rotate_seq

---
 rtl/rotate_pkg.sv | 22 ++
 rtl/mod_counter.sv | 30 +++
 rtl/rotate_seq.sv | 139 +++++++++++++
 tb/tb_rotate_seq.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotate_pkg.sv
// Shared constants, index widths and FSM state encoding for the rotate sequencer.
package rotate_pkg;

   localparam int LANES       = 25;
   localparam int SLICES      = 64;
   localparam int LANE_W      = 5;
   localparam int SLICE_IDX_W = 6;
   localparam int SLICE_W     = 25;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_SWEEP = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   function automatic logic is_busy(input state_t s);
      return (s == ST_FETCH) || (s == ST_WAIT) || (s == ST_SWEEP);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear (priority over enable) and terminal-count flag.
module mod_counter #(
   parameter int MOD = 25,
   parameter int W   = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   output logic [W-1:0] o_value,
   output logic         o_wrap
);

   logic [W-1:0] r_value;

   assign o_wrap  = (r_value == W'(MOD - 1));
   assign o_value = r_value;

   // Count register: clear wins, wraps to zero after MOD-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= {W{1'b0}};
      end else if (i_clr) begin
         r_value <= {W{1'b0}};
      end else if (i_en) begin
         r_value <= o_wrap ? {W{1'b0}} : r_value + W'(1);
      end
   end

endmodule

// File: rtl/rotate_seq.sv
// Rotate-pass sequencer: fetches each slice, then sweeps all lanes issuing write strobes.
// Optional build macro ROTATE_SEQ_STALL_EN adds a stall input that freezes the SWEEP phase.
module rotate_seq #(
   parameter int LANES  = rotate_pkg::LANES,
   parameter int SLICES = rotate_pkg::SLICES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        abort,
`ifdef ROTATE_SEQ_STALL_EN
   input  logic        stall,
`endif
   output logic        rd_en,
   output logic [5:0]  rd_addr,
   input  logic [24:0] rd_data,
   output logic [24:0] slice,
   output logic [5:0]  cnt64_value,
   output logic [4:0]  cnt24_value,
   output logic        wr_en,
   output logic        busy,
   output logic        done
);

   import rotate_pkg::*;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   w_stall;
   logic                   w_adv;
   logic                   w_lane_wrap;
   logic                   w_z_wrap;
   logic [LANE_W-1:0]      w_lane;
   logic [SLICE_IDX_W-1:0] w_z;
   logic [SLICE_W-1:0]     r_slice;
   logic                   r_rd_en;
   logic                   r_wr_en;
   logic                   r_busy;
   logic                   r_done;
   logic                   w_rd_en_nxt;
   logic                   w_wr_en_nxt;
   logic                   w_busy_nxt;
   logic                   w_done_nxt;

`ifdef ROTATE_SEQ_STALL_EN
   assign w_stall = stall & (r_state == ST_SWEEP);
`else
   assign w_stall = 1'b0;
`endif

   assign w_adv = (r_state == ST_SWEEP) & ~w_stall;

   mod_counter #(.MOD(LANES), .W(LANE_W)) u_lane_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_clr   (abort | (r_state == ST_WAIT) | (r_state == ST_DONE)),
      .o_value (w_lane),
      .o_wrap  (w_lane_wrap)
   );

   mod_counter #(.MOD(SLICES), .W(SLICE_IDX_W)) u_slice_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv & w_lane_wrap),
      .i_clr   (abort | (r_state == ST_DONE)),
      .o_value (w_z),
      .o_wrap  (w_z_wrap)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort overrides every transition, including stall.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  w_state_nxt = start ? ST_FETCH : ST_IDLE;
            ST_FETCH: w_state_nxt = ST_WAIT;
            ST_WAIT:  w_state_nxt = ST_SWEEP;
            ST_SWEEP: begin
               if (w_stall || !w_lane_wrap) begin
                  w_state_nxt = ST_SWEEP;
               end else begin
                  w_state_nxt = w_z_wrap ? ST_DONE : ST_FETCH;
               end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Output decode from the next state so the strobes come out of flops.
   always_comb begin
      w_busy_nxt  = is_busy(w_state_nxt);
      w_rd_en_nxt = (w_state_nxt == ST_FETCH);
      w_wr_en_nxt = (w_state_nxt == ST_SWEEP);
      w_done_nxt  = (w_state_nxt == ST_DONE);
   end

   // Registered strobes and the slice captured at the end of WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_en <= 1'b0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_slice <= {SLICE_W{1'b0}};
      end else begin
         r_rd_en <= w_rd_en_nxt;
         r_wr_en <= w_wr_en_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         if (r_state == ST_WAIT) begin
            r_slice <= rd_data;
         end
      end
   end

   assign rd_en       = r_rd_en;
   assign rd_addr     = w_z;
   assign slice       = r_slice;
   assign cnt64_value = w_z;
   assign cnt24_value = w_lane;
   assign wr_en       = r_wr_en & ~w_stall;
   assign busy        = r_busy;
   assign done        = r_done;

endmodule

// File: tb/tb_rotate_seq.sv
// Self-checking bench for rotate_seq: random slice memory, cycle-indexed reference model.
module tb_rotate_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
`ifdef ROTATE_SEQ_STALL_EN
   logic        stall;
`endif
   logic        rd_en;
   logic [5:0]  rd_addr;
   logic [24:0] rd_data;
   logic [24:0] slice;
   logic [5:0]  cnt64_value;
   logic [4:0]  cnt24_value;
   logic        wr_en;
   logic        busy;
   logic        done;

   int          errors = 0;
   int          checks = 0;
   logic [24:0] mem [64];
   logic        prev_rd_en = 1'b0;
   logic [5:0]  prev_addr = 6'd0;

   rotate_seq dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
`ifdef ROTATE_SEQ_STALL_EN
      .stall       (stall),
`endif
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .slice       (slice),
      .cnt64_value (cnt64_value),
      .cnt24_value (cnt24_value),
      .wr_en       (wr_en),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   // Slice memory: returns mem[addr] one cycle after a read strobe, junk otherwise.
   always @(negedge clk) begin
      if (prev_rd_en) rd_data = mem[prev_addr];
      else            rd_data = 25'($urandom);
      prev_rd_en = rd_en;
      prev_addr  = rd_addr;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: step k after the start-sampling edge; 27 steps per slice, step 1729 is DONE.
   task automatic model(input int k, input bit stalled, output logic [45:0] v,
                        output bit ca, output bit cs);
      int s, p;
      logic b, d, r, w;
      logic [5:0]  z;
      logic [4:0]  l;
      logic [24:0] sl;
      b = 1'b0; d = 1'b0; r = 1'b0; w = 1'b0; z = 6'd0; l = 5'd0; sl = 25'd0;
      ca = 1'b0; cs = 1'b0;
      if (k >= 1 && k <= 1728) begin
         s  = (k - 1) / 27;
         p  = (k - 1) % 27;
         b  = 1'b1;
         z  = 6'(s);
         r  = (p == 0);
         cs = (p >= 2);
         w  = cs && !stalled;
         l  = cs ? 5'(p - 2) : 5'd0;
         ca = r;
         sl = cs ? mem[s] : 25'd0;
      end else if (k == 1729) begin
         d = 1'b1;
      end
      v = {b, d, r, w, z, l, (ca ? z : 6'd0), sl};
   endtask

   task automatic test_reset();
      logic [45:0] av;
      rst_n = 1'b0; start = 1'b1; abort = 1'b0;
`ifdef ROTATE_SEQ_STALL_EN
      stall = 1'b0;
`endif
      repeat (3) begin
         @(negedge clk);
         av = {busy, done, rd_en, wr_en, cnt64_value, cnt24_value, rd_addr, slice};
         checks++;
         if (av !== 46'd0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=%h", av, 46'd0);
         end
      end
      start = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, rd_en, wr_en, done} !== 4'd0) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=0000", {busy, rd_en, wr_en, done});
      end
   endtask

   task automatic test_pass(input bit rand_mem, input bit poke_start);
      logic [45:0] ev, av;
      bit ca, cs;
      int wr_cnt, done_cnt, busy_cnt;
      for (int i = 0; i < 64; i++) mem[i] = rand_mem ? 25'($urandom) : {19'd0, 6'(i)};
      wr_cnt = 0; done_cnt = 0; busy_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 1730; k++) begin
         model(k, 1'b0, ev, ca, cs);
         av = {busy, done, rd_en, wr_en, cnt64_value, cnt24_value,
               (ca ? rd_addr : 6'd0), (cs ? slice : 25'd0)};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL pass_step k=%0d got=%h exp=%h", k, av, ev);
         end
         wr_cnt += int'(wr_en); done_cnt += int'(done); busy_cnt += int'(busy);
         start = (poke_start && k == 30 * 27 + 5);
         if (k < 1730) @(negedge clk);
      end
      start = 1'b0;
      checks++;
      if (wr_cnt != 1600) begin errors++; $display("FAIL wr_count got=%0d exp=1600", wr_cnt); end
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL done_count got=%0d exp=1", done_cnt); end
      checks++;
      if (busy_cnt != 1728) begin errors++; $display("FAIL busy_cycles got=%0d exp=1728", busy_cnt); end
   endtask

   task automatic test_abort();
      logic [45:0] ev, av;
      bit ca, cs;
      int seen;
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 280; k++) begin
         model(k, 1'b0, ev, ca, cs);
         av = {busy, done, rd_en, wr_en, cnt64_value, cnt24_value,
               (ca ? rd_addr : 6'd0), (cs ? slice : 25'd0)};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL abort_pre k=%0d got=%h exp=%h", k, av, ev);
         end
         if (k < 280) @(negedge clk);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if ({busy, done, rd_en, wr_en, cnt64_value, cnt24_value} !== 15'd0) begin
         errors++;
         $display("FAIL abort_idle got=%h exp=0", {busy, done, rd_en, wr_en, cnt64_value, cnt24_value});
      end
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         seen += int'(done) + int'(busy);
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if ({busy, rd_en} !== 2'b00) begin errors++; $display("FAIL abort_start_idle got=%b exp=00", {busy, rd_en}); end
      @(negedge clk);
      checks++;
      if ({busy, rd_en} !== 2'b00) begin errors++; $display("FAIL abort_start_queued got=%b exp=00", {busy, rd_en}); end
   endtask

   task automatic test_async_reset();
      logic [45:0] av;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (1089) @(negedge clk);
      checks++;
      if ({busy, cnt64_value, cnt24_value} !== {1'b1, 6'd40, 5'd7}) begin
         errors++;
         $display("FAIL areset_pre got=%h exp=%h", {busy, cnt64_value, cnt24_value}, {1'b1, 6'd40, 5'd7});
      end
      #2 rst_n = 1'b0;
      #1;
      av = {busy, done, rd_en, wr_en, cnt64_value, cnt24_value, rd_addr, slice};
      checks++;
      if (av !== 46'd0) begin errors++; $display("FAIL areset_mid got=%h exp=%h", av, 46'd0); end
      @(negedge clk);
      rst_n = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, rd_en, cnt64_value} !== {1'b1, 1'b1, 6'd0}) begin
         errors++;
         $display("FAIL first_start got=%h exp=%h", {busy, rd_en, cnt64_value}, {1'b1, 1'b1, 6'd0});
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL first_start_abort got=%b exp=0", busy); end
   endtask

`ifdef ROTATE_SEQ_STALL_EN
   task automatic test_stall();
      logic [45:0] ev, av;
      bit ca, cs, st;
      int e, left, wr_cnt, busy_cnt;
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      e = 1; left = 5; wr_cnt = 0; busy_cnt = 0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 1740 && e <= 1730; c++) begin
         st = (e == 5 * 27 + 15) && (left > 0);
         stall = st;
         #1;
         model(e, st, ev, ca, cs);
         av = {busy, done, rd_en, wr_en, cnt64_value, cnt24_value,
               (ca ? rd_addr : 6'd0), (cs ? slice : 25'd0)};
         checks++;
         if (av !== ev) begin
            errors++;
            $display("FAIL stall_step c=%0d got=%h exp=%h", c, av, ev);
         end
         wr_cnt += int'(wr_en); busy_cnt += int'(busy);
         if (st) left--; else e++;
         @(negedge clk);
      end
      stall = 1'b0;
      checks++;
      if (busy_cnt != 1733) begin errors++; $display("FAIL stall_pass_len got=%0d exp=1733", busy_cnt); end
      checks++;
      if (wr_cnt != 1600) begin errors++; $display("FAIL stall_wr_count got=%0d exp=1600", wr_cnt); end
   endtask
`endif

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; rd_data = 25'd0;
      test_reset();
      test_pass(1'b0, 1'b0);
      test_pass(1'b1, 1'b1);
      test_abort();
      test_pass(1'b1, 1'b0);
      test_async_reset();
`ifdef ROTATE_SEQ_STALL_EN
      test_stall();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
